// File: rtl/hann_fft_buf_pkg.sv
// Shared defaults and types for the Hann-to-FFT ping-pong frame buffer.
package hann_fft_buf_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ADDR_W_DEF = 12;
  localparam int unsigned CNT_W_DEF  = 16;
  localparam int unsigned NUM_BANKS  = 2;

  // One bit selects between the two banks
  typedef logic bank_t;

endpackage

// File: rtl/pingpong_dpram.sv
// Simple dual-port RAM holding both banks; bank index is the address MSB.
module pingpong_dpram
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W:0]   wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [ADDR_W:0]   rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  localparam int unsigned DEPTH = 2 ** (ADDR_W + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // Write port; storage is intentionally not reset
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Registered read port, one cycle latency
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/hann_fft_pingpong_buf.sv
// Double-buffered frame store between the Hann window writer and FFT reader.
// Optional saturating dropped-frame counter: define HANN_FFT_BUF_OVERRUN_CNT_EN.
module hann_fft_pingpong_buf
  import hann_fft_buf_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [DATA_W-1:0] memwriter_data,
  input  logic [ADDR_W-1:0] memwriter_addr,
  input  logic              memwriter_valid,
  input  logic              memwriter_last,
  input  logic [ADDR_W-1:0] memreader_addr,
  output logic [DATA_W-1:0] memreader_data,
  output logic              frame_ready,
  input  logic              frame_ack,
  output logic              wr_blocked,
  output logic              wr_bank,
  output logic              rd_bank,
  output logic              overrun,
`ifdef HANN_FFT_BUF_OVERRUN_CNT_EN
  output logic [CNT_W-1:0]  overrun_count,
`endif
  input  logic              overrun_clr
);

  // Reject a degenerate counter width at elaboration
  if (CNT_W == 0) begin : g_cnt_w_chk
    $error("CNT_W must be at least 1");
  end

  logic [NUM_BANKS-1:0] full_q, full_d;
  bank_t                wr_bank_q, wr_bank_d;
  bank_t                rd_bank_q, rd_bank_d;
  logic                 drop_frame_q, drop_frame_d;
  logic                 overrun_q, overrun_d;

  logic blocked;
  logic wr_en;
  logic frame_end;
  logic dropping;
  logic commit;
  logic drop_evt;
  logic frame_rel;

  // Event decode; blocking always looks at the registered bank ownership
  always_comb begin
    blocked   = full_q[wr_bank_q];
    wr_en     = memwriter_valid & ~blocked;
    frame_end = memwriter_valid & memwriter_last;
    dropping  = drop_frame_q | (memwriter_valid & blocked);
    commit    = frame_end & ~dropping;
    drop_evt  = frame_end & dropping;
    frame_rel = frame_ack & full_q[rd_bank_q];
  end

  // Next state: release and commit touch different banks, so both apply
  always_comb begin
    full_d       = full_q;
    wr_bank_d    = wr_bank_q;
    rd_bank_d    = rd_bank_q;
    drop_frame_d = drop_frame_q;
    overrun_d    = overrun_q;

    if (frame_rel) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end

    if (commit) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = ~wr_bank_q;
    end

    if (frame_end) begin
      drop_frame_d = 1'b0;
    end else if (memwriter_valid && blocked) begin
      drop_frame_d = 1'b1;
    end

    if (drop_evt) begin
      overrun_d = 1'b1;
    end else if (overrun_clr) begin
      overrun_d = 1'b0;
    end
  end

  // Control state register
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      full_q       <= '0;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      drop_frame_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      full_q       <= full_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      drop_frame_q <= drop_frame_d;
      overrun_q    <= overrun_d;
    end
  end

  pingpong_dpram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i     (clk_clk),
    .rst_n_i   (reset_reset_n),
    .wr_en_i   (wr_en),
    .wr_addr_i ({wr_bank_q, memwriter_addr}),
    .wr_data_i (memwriter_data),
    .rd_addr_i ({rd_bank_q, memreader_addr}),
    .rd_data_o (memreader_data)
  );

  assign frame_ready = full_q[rd_bank_q];
  assign wr_blocked  = full_q[wr_bank_q];
  assign wr_bank     = wr_bank_q;
  assign rd_bank     = rd_bank_q;
  assign overrun     = overrun_q;

`ifdef HANN_FFT_BUF_OVERRUN_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating drop counter; a drop coincident with clear counts as one
  always_comb begin
    cnt_d = cnt_q;
    if (overrun_clr) begin
      cnt_d = drop_evt ? CNT_W'(1) : '0;
    end else if (drop_evt && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign overrun_count = cnt_q;
`endif

endmodule
